// File: rtl/bcd_dabble_seq_pkg.sv
// Shared constants for the sequential double-dabble binary-to-BCD converter:
// default geometry, FSM state encoding and the saturation pattern.
package bcd_dabble_seq_pkg;

    localparam int DEF_BIN_W      = 16;
    localparam int DEF_DIGITS     = 4;
    localparam int DEF_MAX_VAL    = 9999;
    localparam bit DEF_AUTO_START = 1'b1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [4*DEF_DIGITS-1:0] BCD_SAT = {DEF_DIGITS{4'h9}};

endpackage

// File: rtl/bcd_dabble_seq_add3.sv
// Double-dabble digit corrector: adds 3 to a BCD nibble that is 5 or more so
// the following left shift carries correctly into the next decimal digit.
module bcd_add3 (
    input  logic [3:0] nibble_i,
    output logic [3:0] nibble_o
);

    assign nibble_o = (nibble_i >= 4'd5) ? (nibble_i + 4'd3) : nibble_i;

endmodule

// File: rtl/bcd_dabble_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock.
// The published result (bcd/ovf) only changes in the single DONE cycle.
module bcd_dabble_seq
    import bcd_dabble_seq_pkg::*;
#(
    parameter int BIN_W      = DEF_BIN_W,
    parameter int DIGITS     = DEF_DIGITS,
    parameter int MAX_VAL    = DEF_MAX_VAL,
    parameter bit AUTO_START = DEF_AUTO_START
) (
    input  logic                  clk_50MHz,
    input  logic                  reset,
    input  logic [BIN_W-1:0]      count,
    input  logic                  start,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf
);

    // One spare digit so the full binary range converts cleanly before saturation.
    localparam int WORK_W = 4 * (DIGITS + 1);
    localparam int CNT_W  = $clog2(BIN_W + 1);
    localparam logic [BIN_W-1:0] MAX_W = BIN_W'(MAX_VAL);

    logic [1:0]          state_q, state_d;
    logic [BIN_W-1:0]    bin_sr_q, bin_sr_d;
    logic [BIN_W-1:0]    last_conv_q, last_conv_d;
    logic [WORK_W-1:0]   work_q, work_d, work_adj;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic                trigger;

    for (genvar g = 0; g < DIGITS + 1; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nibble_i (work_q[4*g +: 4]),
            .nibble_o (work_adj[4*g +: 4])
        );
    end

    always_comb begin
        trigger     = start | (AUTO_START & (count != last_conv_q));
        state_d     = state_q;
        bin_sr_d    = bin_sr_q;
        last_conv_d = last_conv_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ovf_d       = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    bin_sr_d    = count;
                    last_conv_d = count;
                    work_d      = '0;
                    cnt_d       = '0;
                    busy_d      = 1'b1;
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {work_d, bin_sr_d} = {work_adj, bin_sr_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (last_conv_q > MAX_W) begin
                    bcd_d = {DIGITS{4'h9}};
                    ovf_d = 1'b1;
                end else begin
                    bcd_d = work_q[4*DIGITS-1:0];
                    ovf_d = 1'b0;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bin_sr_q    <= '0;
            last_conv_q <= '0;
            work_q      <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_sr_q    <= bin_sr_d;
            last_conv_q <= last_conv_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bcd  = bcd_q;
    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bcd_dabble_seq.sv
// Bench for bcd_dabble_seq: one instance with manual start, one self-triggering.
// Expected {ovf, bcd} values come from a decimal model and flow through queues.
module tb_bcd_dabble_seq;

    logic        clk = 1'b0;
    logic        m_reset, m_start, a_reset, a_start;
    logic [15:0] m_count, a_count;
    logic [15:0] m_bcd, a_bcd;
    logic        m_busy, m_done, m_ovf, a_busy, a_done, a_ovf;

    logic [16:0] m_q[$];
    logic [16:0] a_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          m_done_n = 0;
    int          a_done_n = 0;

    always #10 clk = ~clk;

    bcd_dabble_seq #(.AUTO_START(1'b0)) u_dut_man (
        .clk_50MHz (clk), .reset (m_reset), .count (m_count), .start (m_start),
        .bcd (m_bcd), .busy (m_busy), .done (m_done), .ovf (m_ovf)
    );

    bcd_dabble_seq #(.AUTO_START(1'b1)) u_dut_auto (
        .clk_50MHz (clk), .reset (a_reset), .count (a_count), .start (a_start),
        .bcd (a_bcd), .busy (a_busy), .done (a_done), .ovf (a_ovf)
    );

    function automatic logic [16:0] exp_of(input int v);
        if (v > 9999) return {1'b1, 16'h9999};
        return {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Call one step after the trigger edge; returns edges until done and busy samples.
    task automatic wait_done(input bit sel, output int lat, output int busy_n);
        lat    = 0;
        busy_n = ((sel ? a_busy : m_busy) === 1'b1) ? 1 : 0;
        while ((sel ? a_done : m_done) !== 1'b1 && lat < 40) begin
            tick(1);
            lat++;
            if ((sel ? a_busy : m_busy) === 1'b1) busy_n++;
        end
    endtask

    task automatic run_m(input int v);
        int lat, bn;
        m_q.push_back(exp_of(v));
        m_count = 16'(v);
        m_start = 1'b1;
        tick(1);
        m_start = 1'b0;
        wait_done(1'b0, lat, bn);
        check("m_latency", lat, 17);
        check("m_busy_cycles", bn, 17);
        tick(1);
        check("m_done_width", m_done, 1'b0);
    endtask

    // Scoreboard: every done pulse pops and compares one expected result.
    always @(negedge clk) begin
        if (m_done === 1'b1) begin
            m_done_n++;
            if (m_q.size() == 0) check("m_unexpected_done", 1, 0);
            else check("m_result", {m_ovf, m_bcd}, m_q.pop_front());
        end
        if (a_done === 1'b1) begin
            a_done_n++;
            if (a_q.size() == 0) check("a_unexpected_done", 1, 0);
            else check("a_result", {a_ovf, a_bcd}, a_q.pop_front());
        end
    end

    initial begin
        int lat, bn, d0;
        m_reset = 1'b1; a_reset = 1'b1;
        m_start = 1'b0; a_start = 1'b0;
        m_count = '0;   a_count = '0;
        tick(3);
        check("m_reset_out", {m_busy, m_done, m_ovf, m_bcd}, 0);
        check("a_reset_out", {a_busy, a_done, a_ovf, a_bcd}, 0);
        m_reset = 1'b0; a_reset = 1'b0;
        tick(2);

        run_m(0);
        run_m(1234);
        run_m(9999);
        run_m(10);
        run_m(10000);
        run_m(65535);
        run_m(42);

        // Start pulses and count changes during a busy conversion are ignored.
        d0 = m_done_n;
        m_q.push_back(exp_of(777));
        m_count = 16'd777;
        m_start = 1'b1;
        tick(1);
        m_start = 1'b0;
        tick(2);
        m_start = 1'b1;
        m_count = 16'd555;
        tick(1);
        m_start = 1'b0;
        check("m_busy_e3", m_busy, 1'b1);
        tick(6);
        m_start = 1'b1;
        tick(1);
        m_start = 1'b0;
        tick(6);
        check("m_busy_e16", m_busy, 1'b1);
        check("m_bcd_held", {m_ovf, m_bcd}, {1'b0, 16'h0042});
        m_count = 16'd321;
        m_start = 1'b1;
        m_q.push_back(exp_of(321));
        tick(1);
        check("m_done_e17", {m_done, m_busy}, 2'b10);
        tick(1);
        m_start = 1'b0;
        check("m_restart_busy", m_busy, 1'b1);
        check("m_single_done", m_done_n, d0 + 1);
        wait_done(1'b0, lat, bn);
        check("m_restart_latency", lat, 17);
        tick(1);
        check("m_two_done", m_done_n, d0 + 2);

        // Without auto start a changed count alone does nothing.
        m_count = 16'd999;
        tick(30);
        check("m_no_auto", {m_busy, 32'(m_done_n)}, {1'b0, 32'(d0 + 2)});

        // Self-triggering instance follows count changes.
        for (int v = 5; v <= 7; v++) begin
            d0 = a_done_n;
            a_q.push_back(exp_of(v));
            a_count = 16'(v);
            tick(1);
            wait_done(1'b1, lat, bn);
            check("a_latency", lat, 17);
            tick(32);
            check("a_one_done", a_done_n, d0 + 1);
        end
        d0 = a_done_n;
        tick(50);
        check("a_idle_no_done", a_done_n, d0);
        check("a_hold_bcd", {a_ovf, a_bcd}, {1'b0, 16'h0007});

        // Reset in the middle of a conversion aborts it without a done pulse.
        d0 = a_done_n;
        a_count = 16'd4321;
        tick(1);
        check("a_busy_e0", a_busy, 1'b1);
        tick(7);
        a_reset = 1'b1;
        tick(1);
        check("a_abort_out", {a_busy, a_done, a_ovf, a_bcd}, 0);
        a_reset = 1'b0;
        a_q.push_back(exp_of(4321));
        tick(1);
        check("a_abort_no_done", a_done_n, d0);
        wait_done(1'b1, lat, bn);
        check("a_reconv_latency", lat, 17);
        tick(2);
        check("a_reconv_done", a_done_n, d0 + 1);

        check("m_queue_empty", m_q.size(), 0);
        check("a_queue_empty", a_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
